watch_time_ctrl: RTL and testbench

- Timekeeping and set-mode controller for the 4-digit HH:MM watch display.
- Holds BCD time and runs the minute/hour count from a 1 s tick derived from clk.
- Sequences the digit scan and produces the decoder's `control_dig`, `sel`, `key` and `sec_en` inputs.
- Driven by two debounced single-cycle button pulses: mode and increment.

---
 rtl/watch_time_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_watch_time_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl: timekeeping and set-mode controller for a 4-digit HH:MM
// watch display. Keeps BCD time running from a 1 s tick, scans the four
// digits, and lets the user edit one digit at a time with mode/inc buttons.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   mode_pulse   1-cycle pulse, advances RUN->H10->H1->M10->M1->RUN
//   inc_pulse    1-cycle pulse, increments the digit being edited
//   control_dig  current mode code (0 run, 4/3/2/1 = digit being set)
//   sel          scanned digit index (0 = hour tens .. 3 = minute ones)
//   key          BCD value of the scanned digit
//   sec_en       blink enable for the edited digit (1 = visible)
module watch_time_ctrl #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCAN_DIV  = 50_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    output logic [2:0] control_dig,
    output logic [1:0] sel,
    output logic [3:0] key,
    output logic       sec_en
);

    localparam int TW = (CLK_FREQ  > 1) ? $clog2(CLK_FREQ)  : 1;
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(CLK_FREQ - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    // Encoding doubles as the control_dig code seen by the decoder.
    typedef enum logic [2:0] {
        S_RUN = 3'd0,
        S_M1  = 3'd1,
        S_M10 = 3'd2,
        S_H1  = 3'd3,
        S_H10 = 3'd4
    } state_t;

    state_t          r_state, w_next;
    logic [SW-1:0]   r_scan_cnt;
    logic [1:0]      r_sel;
    logic [TW-1:0]   r_tick_cnt;
    logic [5:0]      r_sec;
    logic [3:0]      r_h10, r_h1, r_m10, r_m1;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_sec_en;

    logic            w_inc, w_accept, w_tick, w_min_carry;

    // Mode change wins over an increment arriving in the same cycle.
    assign w_inc       = inc_pulse & ~mode_pulse & (r_state != S_RUN);
    assign w_accept    = mode_pulse | w_inc;
    assign w_tick      = (r_state == S_RUN) && (r_tick_cnt == TICK_MAX);
    assign w_min_carry = w_tick && (r_sec == 6'd59);

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (mode_pulse) begin
            case (r_state)
                S_RUN:   w_next = S_H10;
                S_H10:   w_next = S_H1;
                S_H1:    w_next = S_M10;
                S_M10:   w_next = S_M1;
                S_M1:    w_next = S_RUN;
                default: w_next = S_RUN;
            endcase
        end
    end

    // ---------------- digit scan ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_sel      <= 2'd0;
        end else if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_sel      <= r_sel + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // ---------------- timekeeping and digit editing ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_sec      <= 6'd0;
            r_h10      <= 4'd0;
            r_h1       <= 4'd0;
            r_m10      <= 4'd0;
            r_m1       <= 4'd0;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                r_tick_cnt <= '0;
                r_sec      <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (w_min_carry) begin
                if (r_m1 == 4'd9) begin
                    r_m1 <= 4'd0;
                    if (r_m10 == 4'd5) begin
                        r_m10 <= 4'd0;
                        if (r_h10 == 4'd2 && r_h1 == 4'd3) begin
                            r_h10 <= 4'd0;
                            r_h1  <= 4'd0;
                        end else if (r_h1 == 4'd9) begin
                            r_h1  <= 4'd0;
                            r_h10 <= r_h10 + 4'd1;
                        end else begin
                            r_h1  <= r_h1 + 4'd1;
                        end
                    end else begin
                        r_m10 <= r_m10 + 4'd1;
                    end
                end else begin
                    r_m1 <= r_m1 + 4'd1;
                end
            end
        end else begin
            // Leaving set mode restarts the minute at :00.
            if (mode_pulse && w_next == S_RUN) begin
                r_tick_cnt <= '0;
                r_sec      <= 6'd0;
            end
            if (w_inc) begin
                case (r_state)
                    S_H10: begin
                        if (r_h10 >= 4'd2) begin
                            r_h10 <= 4'd0;
                        end else begin
                            r_h10 <= r_h10 + 4'd1;
                            // Entering 2x: keep the hour legal (<= 23).
                            if (r_h10 == 4'd1 && r_h1 > 4'd3) r_h1 <= 4'd3;
                        end
                    end
                    S_H1: begin
                        if ((r_h10 == 4'd2) ? (r_h1 >= 4'd3) : (r_h1 >= 4'd9))
                            r_h1 <= 4'd0;
                        else
                            r_h1 <= r_h1 + 4'd1;
                    end
                    S_M10:   r_m10 <= (r_m10 >= 4'd5) ? 4'd0 : r_m10 + 4'd1;
                    S_M1:    r_m1  <= (r_m1  >= 4'd9) ? 4'd0 : r_m1  + 4'd1;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- blink ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_sec_en    <= 1'b1;
        end else if (r_state == S_RUN || w_accept) begin
            // Any accepted press shows the edited digit right away.
            r_blink_cnt <= '0;
            r_sec_en    <= 1'b1;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_sec_en    <= ~r_sec_en;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        key = r_h10;
        case (r_sel)
            2'd0: key = r_h10;
            2'd1: key = r_h1;
            2'd2: key = r_m10;
            2'd3: key = r_m1;
            default: key = r_h10;
        endcase
    end

    assign control_dig = r_state;
    assign sel         = r_sel;
    assign sec_en      = r_sec_en;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// tb_watch_time_ctrl: directed bench for watch_time_ctrl. A behavioural model
// (time held as hours/minutes integers, mode as an index) predicts every
// output each cycle; directed steps add literal expectations on top.
module tb_watch_time_ctrl;

    localparam int CLK_FREQ  = 20;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mode_pulse = 1'b0;
    logic       inc_pulse = 1'b0;
    logic [2:0] control_dig;
    logic [1:0] sel;
    logic [3:0] key;
    logic       sec_en;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    watch_time_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_pulse (mode_pulse),
        .inc_pulse  (inc_pulse),
        .control_dig(control_dig),
        .sel        (sel),
        .key        (key),
        .sec_en     (sec_en)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 run, 1 hour tens, 2 hour ones, 3 minute tens, 4 minute ones
    typedef struct packed {
        int mode; int hr; int mn; int sec; int tick;
        int scan; int sel; int bcnt; int vis;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t n;
        n.mode = 0; n.hr = 0; n.mn = 0; n.sec = 0; n.tick = 0;
        n.scan = 0; n.sel = 0; n.bcnt = 0; n.vis = 1;
        return n;
    endfunction

    function automatic model_t step(model_t c, bit mp, bit ip);
        model_t n;
        bit acc;
        int t, ht, ho, mt, mo;
        n = c;
        acc = mp || (ip && c.mode != 0);
        n.scan = c.scan + 1;
        if (n.scan == SCAN_DIV) begin
            n.scan = 0;
            n.sel  = (c.sel + 1) % 4;
        end
        if (c.mode == 0 || acc) begin
            n.vis = 1; n.bcnt = 0;
        end else begin
            n.bcnt = c.bcnt + 1;
            if (n.bcnt == BLINK_DIV) begin
                n.bcnt = 0; n.vis = 1 - c.vis;
            end
        end
        if (c.mode == 0) begin
            n.tick = c.tick + 1;
            if (n.tick == CLK_FREQ) begin
                n.tick = 0;
                n.sec  = c.sec + 1;
                if (n.sec == 60) begin
                    n.sec = 0;
                    t = (c.hr * 60 + c.mn + 1) % 1440;
                    n.hr = t / 60;
                    n.mn = t % 60;
                end
            end
        end else if (ip && !mp) begin
            ht = c.hr / 10; ho = c.hr % 10; mt = c.mn / 10; mo = c.mn % 10;
            case (c.mode)
                1: begin ht = (ht + 1) % 3; if (ht == 2 && ho > 3) ho = 3; end
                2: ho = (ho + 1) % ((ht == 2) ? 4 : 10);
                3: mt = (mt + 1) % 6;
                4: mo = (mo + 1) % 10;
                default: ;
            endcase
            n.hr = ht * 10 + ho;
            n.mn = mt * 10 + mo;
        end
        if (mp) begin
            if (c.mode == 4) begin n.sec = 0; n.tick = 0; end
            n.mode = (c.mode + 1) % 5;
        end
        return n;
    endfunction

    function automatic int code_of(int mode);
        case (mode)
            1: return 4;
            2: return 3;
            3: return 2;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int digit_of(model_t c);
        case (c.sel)
            0: return c.hr / 10;
            1: return c.hr % 10;
            2: return c.mn / 10;
            default: return c.mn % 10;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= step(m, mode_pulse, inc_pulse);
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_control_dig", int'(control_dig), code_of(m.mode));
            chk("cyc_sel",         int'(sel),         m.sel);
            chk("cyc_key",         int'(key),         digit_of(m));
            chk("cyc_sec_en",      int'(sec_en),      m.vis);
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic press_mode();
        mode_pulse = 1'b1;
        @(negedge clk);
        mode_pulse = 1'b0;
    endtask

    task automatic press_inc(input int times);
        for (int i = 0; i < times; i++) begin
            inc_pulse = 1'b1;
            @(negedge clk);
            inc_pulse = 1'b0;
        end
    endtask

    task automatic wait_sel(input int d);
        int n;
        n = 0;
        while (int'(sel) != d && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (int'(sel) != d) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_sel: sel stuck at %0d, expected to reach %0d", sel, d);
        end
    endtask

    int m10_seq[6] = '{1, 2, 3, 4, 5, 0};

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and free-running scan
        chk("rst_control_dig", int'(control_dig), 0);
        chk("rst_sec_en",      int'(sec_en),      1);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            chk("scan_sel", int'(sel), (i / 4) % 4);
            chk("scan_key", int'(key), 0);
        end

        // Preload 23:59, return to RUN, roll over midnight
        press_mode(); press_inc(2);
        press_mode(); press_inc(3);
        press_mode(); press_inc(5);
        press_mode(); press_inc(9);
        chk("preload_hr", m.hr, 23);
        chk("preload_mn", m.mn, 59);
        press_mode();
        chk("back_to_run", int'(control_dig), 0);
        repeat (1199) @(negedge clk);
        chk("pre_roll_hr",  m.hr, 23);
        chk("pre_roll_mn",  m.mn, 59);
        chk("pre_roll_sec", m.sec, 59);
        @(negedge clk);
        chk("roll_hr",  m.hr, 0);
        chk("roll_mn",  m.mn, 0);
        chk("roll_sec", m.sec, 0);
        for (int d = 0; d < 4; d++) begin
            wait_sel(d);
            chk("roll_key", int'(key), 0);
        end

        // Hour ones 9, then hour tens to 2 forces ones to 3
        press_mode(); press_mode(); press_inc(9);
        press_mode(); press_mode(); press_mode(); press_mode();
        chk("h10_state", int'(control_dig), 4);
        chk("h1_nine", m.hr, 9);
        press_inc(2);
        wait_sel(0); chk("h10_two",    int'(key), 2);
        wait_sel(1); chk("h1_forced",  int'(key), 3);
        press_inc(1);
        wait_sel(0); chk("h10_wrap",   int'(key), 0);
        wait_sel(1); chk("h1_kept",    int'(key), 3);

        // Minute tens wraps 0..5 with no carry
        press_mode(); press_mode();
        chk("m10_state", int'(control_dig), 2);
        for (int i = 0; i < 6; i++) begin
            press_inc(1);
            wait_sel(2);
            chk("m10_seq", int'(key), m10_seq[i]);
        end
        wait_sel(0); chk("m10_h10_same", int'(key), 0);
        wait_sel(1); chk("m10_h1_same",  int'(key), 3);
        wait_sel(3); chk("m10_m1_same",  int'(key), 0);

        // Full mode cycle, blink period and blink restart on inc
        press_mode(); press_mode();
        chk("cycle_run", int'(control_dig), 0);
        press_mode();
        chk("cycle_4", int'(control_dig), 4);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            chk("blink", int'(sec_en), (i < 6) ? 1 : 0);
        end
        press_inc(1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            chk("blink_after_inc", int'(sec_en), (i < 6) ? 1 : 0);
        end
        chk("inc_hr_13", m.hr, 13);
        press_mode(); chk("cycle_3", int'(control_dig), 3);
        press_mode(); chk("cycle_2", int'(control_dig), 2);
        press_mode(); chk("cycle_1", int'(control_dig), 1);
        press_mode(); chk("cycle_0", int'(control_dig), 0);

        // Simultaneous mode+inc in H1: mode wins, digit untouched
        press_mode(); press_mode();
        chk("h1_state", int'(control_dig), 3);
        mode_pulse = 1'b1;
        inc_pulse  = 1'b1;
        @(negedge clk);
        mode_pulse = 1'b0;
        inc_pulse  = 1'b0;
        chk("both_state", int'(control_dig), 2);
        chk("both_hr", m.hr, 13);
        wait_sel(1); chk("both_h1_key", int'(key), 3);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_control_dig", int'(control_dig), 0);
        chk("async_sel",         int'(sel),         0);
        chk("async_key",         int'(key),         0);
        chk("async_sec_en",      int'(sec_en),      1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
